// File: rtl/i2c_slave_8bit_pkg.sv
// rtl/i2c_slave_8bit_pkg.sv - shared states, bus constants and helpers for the I2C target
package i2c_slave_8bit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic addr_match(input logic [7:0] rx_byte, input logic [6:0] addr);
    return rx_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_slave_8bit_if.sv
// rtl/i2c_slave_8bit_if.sv - SDA/SCL pads plus rx/tx byte handshakes of the I2C target
interface i2c_slave_8bit_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       sda_t;
  logic       o_rvalid;
  logic       i_rready;
  logic [7:0] o_rdata;
  logic       o_rfirst;
  logic       i_wvalid;
  logic       o_wready;
  logic [7:0] i_wdata;

  modport slave (
    input  scl_i, sda_i, i_rready, i_wvalid, i_wdata,
    output sda_o, sda_t, o_rvalid, o_rdata, o_rfirst, o_wready
  );

  modport master (
    output scl_i, sda_i, i_rready, i_wvalid, i_wdata,
    input  sda_o, sda_t, o_rvalid, o_rdata, o_rfirst, o_wready
  );
endinterface

// File: rtl/i2c_slave_8bit_line_filter.sv
// rtl/i2c_slave_8bit_line_filter.sv - 2-FF sync, glitch filter and edge strobes for one pad
module i2c_slave_8bit_line_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // An idle bus is high, so the filter comes out of reset at 1 and no edge fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_8bit.sv
// rtl/i2c_slave_8bit.sv - I2C target byte engine: address match, byte receive and transmit
module i2c_slave_8bit
  import i2c_slave_8bit_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  i2c_slave_8bit_if.slave bus,
  output logic            o_start,
  output logic            o_stop,
  output logic            o_addr_hit,
  output logic            o_rw,
  output logic            o_busy,
  output logic            o_nack,
  output logic            o_underrun
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_slave_8bit_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .din(bus.scl_i),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_slave_8bit_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .din(bus.sda_i),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall && scl;
  assign stop_det  = sda_rise && scl;

  i2c_state_e state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] rx_sh, rx_sh_n, tx_sh, tx_sh_n;
  logic [7:0] rdata_q, rdata_n, hold_q, hold_n;
  logic       sda_t_q, sda_t_n;
  logic       rvalid_q, rvalid_n, rfirst_q, rfirst_n, first_q, first_n;
  logic       hold_full_q, hold_full_n, rw_q, rw_n, busy_q, busy_n;
  logic       start_n, stop_n, hit_n, nack_n, under_n;
  logic       load_tx, rx_free;
  logic [7:0] rx_byte, tx_src;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rx_sh_n     = rx_sh;
    tx_sh_n     = tx_sh;
    rdata_n     = rdata_q;
    hold_n      = hold_q;
    sda_t_n     = sda_t_q;
    rvalid_n    = rvalid_q;
    rfirst_n    = rfirst_q;
    first_n     = first_q;
    hold_full_n = hold_full_q;
    rw_n        = rw_q;
    busy_n      = busy_q;
    start_n     = 1'b0;
    stop_n      = 1'b0;
    hit_n       = 1'b0;
    nack_n      = 1'b0;
    under_n     = 1'b0;
    load_tx     = 1'b0;
    rx_byte     = {rx_sh[6:0], sda};
    // The user draining the old byte on this very cycle frees room for the new one.
    rx_free     = !rvalid_q || bus.i_rready;
    tx_src      = hold_full_q ? hold_q : 8'hFF;

    if (rvalid_q && bus.i_rready) rvalid_n = 1'b0;

    if (stop_det) begin
      state_n = ST_IDLE;
      cnt_n   = 3'd0;
      sda_t_n = 1'b0;
      busy_n  = 1'b0;
      stop_n  = 1'b1;
    end else if (start_det) begin
      state_n = ST_ADDR;
      cnt_n   = 3'd0;
      sda_t_n = 1'b0;
      start_n = 1'b1;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          rx_sh_n = rx_byte;
          if (cnt == 3'd7) begin
            cnt_n = 3'd0;
            if (addr_match(rx_byte, SLAVE_ADDR)) begin
              hit_n   = 1'b1;
              rw_n    = rx_byte[0];
              busy_n  = 1'b1;
              first_n = ~rx_byte[0];
              state_n = ST_ADDR_ACK;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        // First SCL fall asserts the ACK, the next one releases it.
        ST_ADDR_ACK, ST_RX_ACK: if (scl_fall) begin
          if (!sda_t_q) begin
            sda_t_n = 1'b1;
          end else if (state == ST_ADDR_ACK && rw_q) begin
            load_tx = 1'b1;
          end else begin
            sda_t_n = 1'b0;
            state_n = ST_RX;
          end
        end
        ST_RX: if (scl_rise) begin
          rx_sh_n = rx_byte;
          if (cnt == 3'd7) begin
            cnt_n = 3'd0;
            if (rx_free) begin
              rdata_n  = rx_byte;
              rvalid_n = 1'b1;
              rfirst_n = first_q;
              first_n  = 1'b0;
              state_n  = ST_RX_ACK;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        ST_TX: if (scl_fall) begin
          if (cnt == 3'd7) begin
            cnt_n   = 3'd0;
            sda_t_n = 1'b0;
            state_n = ST_TX_ACK;
          end else begin
            sda_t_n = ~tx_sh[7];
            tx_sh_n = {tx_sh[6:0], 1'b1};
            cnt_n   = cnt + 3'd1;
          end
        end
        // A NACK leaves on the rise, so any fall seen here follows an ACK.
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda == NACK) begin
              nack_n  = 1'b1;
              state_n = ST_WAIT_STOP;
            end
          end else if (scl_fall) begin
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load_tx) begin
      state_n = ST_TX;
      cnt_n   = 3'd0;
      sda_t_n = ~tx_src[7];
      tx_sh_n = {tx_src[6:0], 1'b1};
      if (hold_full_q) hold_full_n = 1'b0;
      else             under_n     = 1'b1;
    end

    if (bus.i_wvalid && !hold_full_q) begin
      hold_n      = bus.i_wdata;
      hold_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 3'd0;
      rx_sh       <= 8'h00;
      tx_sh       <= 8'h00;
      rdata_q     <= 8'h00;
      hold_q      <= 8'h00;
      sda_t_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rfirst_q    <= 1'b0;
      first_q     <= 1'b0;
      hold_full_q <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      o_start     <= 1'b0;
      o_stop      <= 1'b0;
      o_addr_hit  <= 1'b0;
      o_nack      <= 1'b0;
      o_underrun  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rx_sh       <= rx_sh_n;
      tx_sh       <= tx_sh_n;
      rdata_q     <= rdata_n;
      hold_q      <= hold_n;
      sda_t_q     <= sda_t_n;
      rvalid_q    <= rvalid_n;
      rfirst_q    <= rfirst_n;
      first_q     <= first_n;
      hold_full_q <= hold_full_n;
      rw_q        <= rw_n;
      busy_q      <= busy_n;
      o_start     <= start_n;
      o_stop      <= stop_n;
      o_addr_hit  <= hit_n;
      o_nack      <= nack_n;
      o_underrun  <= under_n;
    end
  end

  assign bus.sda_o    = 1'b0;
  assign bus.sda_t    = sda_t_q;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_rfirst = rfirst_q;
  assign bus.o_wready = ~hold_full_q;
  assign o_rw         = rw_q;
  assign o_busy       = busy_q;

endmodule
